// File: rtl/dm_arbiter_if.sv
// Requester handshake and memory bus shared by the data-memory arbiter.
`timescale 1ns/1ps
interface dm_arbiter_if #(
  parameter int unsigned WIDTH = 32
);
  logic             REQ0;
  logic             REQ1;
  logic             WE0;
  logic             WE1;
  logic [WIDTH-1:0] A0;
  logic [WIDTH-1:0] A1;
  logic [WIDTH-1:0] WD0;
  logic [WIDTH-1:0] WD1;
  logic [WIDTH-1:0] RD0;
  logic [WIDTH-1:0] RD1;
  logic             ACK0;
  logic             ACK1;
  logic             ERR0;
  logic             ERR1;
  logic             MEM_WE;
  logic [WIDTH-1:0] MEM_A;
  logic [WIDTH-1:0] MEM_WD;
  logic [WIDTH-1:0] MEM_RD;

  // Requesters plus memory: drive requests and read data, observe the rest.
  modport master (
    output REQ0, REQ1, WE0, WE1, A0, A1, WD0, WD1, MEM_RD,
    input  RD0, RD1, ACK0, ACK1, ERR0, ERR1, MEM_WE, MEM_A, MEM_WD
  );

  // Arbiter side.
  modport slave (
    input  REQ0, REQ1, WE0, WE1, A0, A1, WD0, WD1, MEM_RD,
    output RD0, RD1, ACK0, ACK1, ERR0, ERR1, MEM_WE, MEM_A, MEM_WD
  );
endinterface

// File: rtl/dm_arbiter.sv
// Round-robin arbiter sharing a single-port data memory between the CPU
// datapath (port 0) and the loader/debug port (port 1). One access per
// grant: IDLE/RESP arbitrate, ACCESS drives the memory, RESP pulses ACK.
`timescale 1ns/1ps
module dm_arbiter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 64
) (
  input  logic         CLK,
  input  logic         RST,
  dm_arbiter_if.slave  bus
);

  localparam logic [WIDTH-1:0] DepthW = WIDTH'(DEPTH);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t           state_q;
  logic             owner_q;
  logic             last_q;
  logic             we_q;
  logic [WIDTH-1:0] addr_q;
  logic [WIDTH-1:0] wdata_q;
  logic             oor_q;
  logic [WIDTH-1:0] rd0_q;
  logic [WIDTH-1:0] rd1_q;
  logic             ack0_q;
  logic             ack1_q;
  logic             err0_q;
  logic             err1_q;

  logic             cand0_d;
  logic             cand1_d;
  logic             win_valid_d;
  logic             win_port_d;
  logic             sel_we_d;
  logic [WIDTH-1:0] sel_a_d;
  logic [WIDTH-1:0] sel_wd_d;

  // Candidate selection: the owner in RESP still holds REQ, so it is excluded.
  always_comb begin
    cand0_d = bus.REQ0;
    cand1_d = bus.REQ1;
    if (state_q == RESP) begin
      if (owner_q) cand1_d = 1'b0;
      else         cand0_d = 1'b0;
    end
    win_valid_d = cand0_d | cand1_d;
    win_port_d  = (cand0_d & cand1_d) ? ~last_q : cand1_d;
    sel_we_d    = win_port_d ? bus.WE1 : bus.WE0;
    sel_a_d     = win_port_d ? bus.A1  : bus.A0;
    sel_wd_d    = win_port_d ? bus.WD1 : bus.WD0;
  end

  // Control FSM with registered grant, read data and ACK/ERR pulses.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      oor_q   <= 1'b0;
      rd0_q   <= '0;
      rd1_q   <= '0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      err0_q  <= 1'b0;
      err1_q  <= 1'b0;
    end else begin
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      err0_q <= 1'b0;
      err1_q <= 1'b0;
      case (state_q)
        IDLE, RESP: begin
          if (win_valid_d) begin
            owner_q <= win_port_d;
            last_q  <= win_port_d;
            we_q    <= sel_we_d;
            addr_q  <= sel_a_d;
            wdata_q <= sel_wd_d;
            oor_q   <= (sel_a_d >= DepthW);
            state_q <= ACCESS;
          end else begin
            state_q <= IDLE;
          end
        end
        ACCESS: begin
          // Writes also return the pre-write word; rejected accesses return 0.
          if (owner_q) begin
            ack1_q <= 1'b1;
            err1_q <= oor_q;
            rd1_q  <= oor_q ? '0 : bus.MEM_RD;
          end else begin
            ack0_q <= 1'b1;
            err0_q <= oor_q;
            rd0_q  <= oor_q ? '0 : bus.MEM_RD;
          end
          state_q <= RESP;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Write strobe gated by RST so an aborted access never commits.
  assign bus.MEM_WE = (state_q == ACCESS) & we_q & ~oor_q & ~RST;
  assign bus.MEM_A  = addr_q;
  assign bus.MEM_WD = wdata_q;
  assign bus.RD0    = rd0_q;
  assign bus.RD1    = rd1_q;
  assign bus.ACK0   = ack0_q;
  assign bus.ACK1   = ack1_q;
  assign bus.ERR0   = err0_q;
  assign bus.ERR1   = err1_q;

endmodule
